stack_engine: RTL and testbench
===============================

STACK_ENGINE -- requirements
Module: stack_engine

Interface
REQ-001 Parameter: WIDTH, default 4, data word width in bits (1..32).
REQ-002 Parameter: DEPTH, default 5, number of storage entries (2..64).
REQ-003 Derived parameters: IDXW = clog2(DEPTH), CNTW = clog2(DEPTH+1); both are localparams, not overridable.
REQ-004 Port: CLK  input  1  clock; all state changes on the rising edge.
REQ-005 Port: RESET  input  1  reset, synchronous, active-high.
REQ-006 Port: CMD  input  2  command: 00 NOP, 01 PUSH, 10 POP, 11 PEEK.
REQ-007 Port: INDEX  input  IDXW  PEEK depth; 0 = top, 1 = one below top, and so on.
REQ-008 Port: DIN  input  WIDTH  PUSH data.
REQ-009 Port: DOUT  output  WIDTH  registered read data from POP or PEEK.
REQ-010 Port: DOUT_VALID  output  1  DOUT was updated by the command sampled at the last edge.
REQ-011 Port: COUNT  output  CNTW  number of valid entries (0..DEPTH).
REQ-012 Port: FULL  output  1  COUNT == DEPTH (combinational from COUNT).
REQ-013 Port: EMPTY  output  1  COUNT == 0 (combinational from COUNT).
REQ-014 Port: ERR  output  1  one-cycle pulse marking a rejected command.

Function
REQ-015 The block samples CMD, INDEX and DIN once per rising CLK edge; there is no level-sensitive or edge-detect behaviour.
REQ-016 Storage is a DEPTH x WIDTH circular array with top pointer TOP (IDXW bits); all pointer arithmetic is modulo DEPTH, and no pointer may leave the range 0..DEPTH-1.
REQ-017 NOP leaves storage, TOP, COUNT and DOUT unchanged; DOUT_VALID=0; ERR=0.
REQ-018 PUSH when not FULL: TOP <= (TOP+1) mod DEPTH; stack[new TOP] <= DIN; COUNT <= COUNT+1; DOUT_VALID=0; ERR=0.
REQ-019 POP when not EMPTY: DOUT <= stack[TOP]; TOP <= (TOP+DEPTH-1) mod DEPTH; COUNT <= COUNT-1; DOUT_VALID=1 in the following cycle.
REQ-020 PEEK with INDEX < COUNT: DOUT <= stack[(TOP+DEPTH-INDEX) mod DEPTH]; TOP and COUNT unchanged; DOUT_VALID=1.
REQ-021 Latency: DOUT and DOUT_VALID reflect the command one edge after it is sampled, and DOUT holds its value until the next successful POP or PEEK.
REQ-022 POP when EMPTY: no state change; DOUT held; DOUT_VALID=0; ERR=1 for one cycle.
REQ-023 PEEK with INDEX >= COUNT, including INDEX >= DEPTH: no state change; DOUT held; DOUT_VALID=0; ERR=1.
REQ-024 PUSH when FULL follows REQ-039 and REQ-040.
REQ-025 Back-to-back commands on consecutive edges are fully supported; a POP directly after a PUSH returns the just-pushed value.
REQ-026 Continuous PUSH/POP cycling SHALL wrap TOP across DEPTH-1 -> 0 and 0 -> DEPTH-1 with no data corruption.
REQ-027 DOUT_VALID and ERR are registered and are never both 1 in the same cycle.

Reset
REQ-028 RESET takes priority over any CMD sampled on the same edge.
REQ-029 When RESET is asserted at an edge: TOP <= 0; COUNT <= 0; DOUT <= 0; DOUT_VALID <= 0; ERR <= 0.
REQ-030 All storage entries are cleared to 0 on reset.
REQ-031 After reset, outputs read FULL=0 and EMPTY=1.
REQ-032 Reset asserted in the middle of a command sequence discards all pending state; the first command after RESET deasserts behaves as on an empty stack.
REQ-033 There is no power-up state requirement beyond the first reset; the bench SHALL apply RESET before any stimulus.

Configuration
REQ-034 Macro STACK_ENGINE_CIRCULAR_EN selects the full-PUSH policy.
REQ-035 Without STACK_ENGINE_CIRCULAR_EN, PUSH when FULL is rejected: no state change; ERR=1.
REQ-036 With STACK_ENGINE_CIRCULAR_EN, PUSH when FULL overwrites the oldest entry: TOP <= (TOP+1) mod DEPTH; stack[new TOP] <= DIN; COUNT stays DEPTH; ERR=0.
REQ-037 POP-empty and PEEK-out-of-range behaviour is identical in both builds.
REQ-038 The macro SHALL NOT change the port list or parameters.
REQ-039 The without-macro build rejects PUSH when FULL as stated in REQ-035.
REQ-040 The with-macro build overwrites on PUSH when FULL as stated in REQ-036.

Verification
REQ-041 Default parameters: RESET; PUSH 3, 7, 9; POP x3 -> DOUT 9, 7, 3 with DOUT_VALID=1; then EMPTY=1 and COUNT=0.
REQ-042 PUSH 1..5 (FULL=1); PEEK INDEX 0, 2, 4 -> DOUT 5, 3, 1; PEEK INDEX 5 -> ERR=1, DOUT stays 1.
REQ-043 Without macro: PUSH 1..5, then PUSH 6 -> ERR=1 and COUNT=5; POP x5 -> 5, 4, 3, 2, 1.
REQ-044 With macro: PUSH 1..6 -> ERR never 1, COUNT=5; POP x5 -> 6, 5, 4, 3, 2; a sixth POP -> ERR=1.
REQ-045 WIDTH=8, DEPTH=4: PUSH 0xA5 with RESET high on the same edge -> COUNT=0, DOUT=0, EMPTY=1; then POP -> ERR=1.

Source files
------------

// File: rtl/stack_engine.sv
// rtl/stack_engine.sv - circular-array LIFO with PUSH/POP/PEEK commands and registered read data
// Optional STACK_ENGINE_CIRCULAR_EN: PUSH on a full stack overwrites the oldest entry instead of erroring.
module stack_engine #(
    parameter int WIDTH = 4,
    parameter int DEPTH = 5,
    localparam int IDXW = $clog2(DEPTH),
    localparam int CNTW = $clog2(DEPTH + 1)
) (
    input  logic             CLK,
    input  logic             RESET,
    input  logic [1:0]       CMD,
    input  logic [IDXW-1:0]  INDEX,
    input  logic [WIDTH-1:0] DIN,
    output logic [WIDTH-1:0] DOUT,
    output logic             DOUT_VALID,
    output logic [CNTW-1:0]  COUNT,
    output logic             FULL,
    output logic             EMPTY,
    output logic             ERR
);
    localparam logic [1:0] CMD_PUSH = 2'b01;
    localparam logic [1:0] CMD_POP  = 2'b10;
    localparam logic [1:0] CMD_PEEK = 2'b11;

    localparam int AW = IDXW + 1;
    localparam logic [AW-1:0]   DEPTH_A = AW'(DEPTH);
    localparam logic [CNTW-1:0] DEPTH_C = CNTW'(DEPTH);
    localparam logic [IDXW-1:0] LAST    = IDXW'(DEPTH - 1);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [IDXW-1:0]  top;
    logic [IDXW-1:0]  top_inc;
    logic [IDXW-1:0]  top_dec;
    logic [AW-1:0]    peek_sum;
    logic [AW-1:0]    peek_wide;
    logic [IDXW-1:0]  peek_addr;
    logic             peek_ok;

    assign FULL  = (COUNT == DEPTH_C);
    assign EMPTY = (COUNT == '0);

    // Explicit wrap instead of modulo so DEPTH need not be a power of two.
    assign top_inc = (top == LAST) ? '0 : top + 1'b1;
    assign top_dec = (top == '0) ? LAST : top - 1'b1;

    assign peek_ok   = (CNTW'(INDEX) < COUNT);
    assign peek_sum  = {1'b0, top} + DEPTH_A - {1'b0, INDEX};
    assign peek_wide = (peek_sum >= DEPTH_A) ? peek_sum - DEPTH_A : peek_sum;
    assign peek_addr = peek_wide[IDXW-1:0];

    always_ff @(posedge CLK) begin
        if (RESET) begin
            top        <= '0;
            COUNT      <= '0;
            DOUT       <= '0;
            DOUT_VALID <= 1'b0;
            ERR        <= 1'b0;
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
        end else begin
            DOUT_VALID <= 1'b0;
            ERR        <= 1'b0;
            case (CMD)
                CMD_PUSH: begin
                    if (!FULL) begin
                        top          <= top_inc;
                        mem[top_inc] <= DIN;
                        COUNT        <= COUNT + 1'b1;
                    end else begin
`ifdef STACK_ENGINE_CIRCULAR_EN
                        top          <= top_inc;
                        mem[top_inc] <= DIN;
`else
                        ERR          <= 1'b1;
`endif
                    end
                end
                CMD_POP: begin
                    if (EMPTY) begin
                        ERR <= 1'b1;
                    end else begin
                        DOUT       <= mem[top];
                        DOUT_VALID <= 1'b1;
                        top        <= top_dec;
                        COUNT      <= COUNT - 1'b1;
                    end
                end
                CMD_PEEK: begin
                    if (peek_ok) begin
                        DOUT       <= mem[peek_addr];
                        DOUT_VALID <= 1'b1;
                    end else begin
                        ERR <= 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end
endmodule

// File: tb/tb_stack_engine.sv
// tb/tb_stack_engine.sv - directed-vector bench for stack_engine (default and 8x4 instances)
module tb_stack_engine;
    localparam logic [1:0] NOP  = 2'b00;
    localparam logic [1:0] PUSH = 2'b01;
    localparam logic [1:0] POP  = 2'b10;
    localparam logic [1:0] PEEK = 2'b11;

    logic       CLK = 1'b0;
    logic       RESET;
    logic [1:0] CMD;
    logic [2:0] INDEX;
    logic [3:0] DIN;
    logic [3:0] DOUT;
    logic       DOUT_VALID;
    logic [2:0] COUNT;
    logic       FULL, EMPTY, ERR;

    logic       r2;
    logic [1:0] c2;
    logic [1:0] i2;
    logic [7:0] d2;
    logic [7:0] q2;
    logic       v2;
    logic [2:0] n2;
    logic       f2, e2, x2;

    int n_vec = 0;
    int n_bad = 0;

    always #5 CLK = ~CLK;

    stack_engine dut (
        .CLK(CLK), .RESET(RESET), .CMD(CMD), .INDEX(INDEX), .DIN(DIN),
        .DOUT(DOUT), .DOUT_VALID(DOUT_VALID), .COUNT(COUNT),
        .FULL(FULL), .EMPTY(EMPTY), .ERR(ERR)
    );

    stack_engine #(.WIDTH(8), .DEPTH(4)) dut8 (
        .CLK(CLK), .RESET(r2), .CMD(c2), .INDEX(i2), .DIN(d2),
        .DOUT(q2), .DOUT_VALID(v2), .COUNT(n2),
        .FULL(f2), .EMPTY(e2), .ERR(x2)
    );

    task automatic expect_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic step(input logic [1:0] c, input logic [2:0] idx, input logic [3:0] d);
        CMD   = c;
        INDEX = idx;
        DIN   = d;
        @(posedge CLK);
        #1;
        CMD = NOP;
    endtask

    task automatic pop_expect(input string tag, input logic [3:0] exp);
        step(POP, 3'd0, 4'd0);
        expect_eq(tag, {DOUT_VALID, ERR, DOUT}, {1'b1, 1'b0, exp});
    endtask

    initial begin
        RESET = 1'b1; CMD = NOP; INDEX = '0; DIN = '0;
        r2 = 1'b1; c2 = NOP; i2 = '0; d2 = '0;
        repeat (2) @(posedge CLK);
        #1;
        RESET = 1'b0;
        r2 = 1'b0;
        expect_eq("rst_count", COUNT, 0);
        expect_eq("rst_flags", {FULL, EMPTY, DOUT_VALID, ERR}, 4'b0100);
        expect_eq("rst_dout", DOUT, 0);

        // Basic LIFO order
        step(PUSH, 0, 4'd3);
        step(PUSH, 0, 4'd7);
        expect_eq("push_novalid", {DOUT_VALID, ERR}, 2'b00);
        step(PUSH, 0, 4'd9);
        expect_eq("count3", COUNT, 3);
        pop_expect("pop9", 4'd9);
        pop_expect("pop7", 4'd7);
        pop_expect("pop3", 4'd3);
        expect_eq("empty_after", {EMPTY, COUNT}, {1'b1, 3'd0});
        step(POP, 0, 0);
        expect_eq("pop_empty", {DOUT_VALID, ERR, DOUT}, {1'b0, 1'b1, 4'd3});
        step(NOP, 0, 0);
        expect_eq("err_pulse", {DOUT_VALID, ERR}, 2'b00);

        // Fill across the wrap point, then PEEK
        for (int k = 1; k <= 5; k++) step(PUSH, 0, 4'(k));
        expect_eq("full", {FULL, EMPTY, COUNT}, {1'b1, 1'b0, 3'd5});
        step(PEEK, 0, 0);
        expect_eq("peek0", {DOUT_VALID, ERR, DOUT}, {1'b1, 1'b0, 4'd5});
        step(PEEK, 2, 0);
        expect_eq("peek2", {DOUT_VALID, ERR, DOUT}, {1'b1, 1'b0, 4'd3});
        step(PEEK, 4, 0);
        expect_eq("peek4", {DOUT_VALID, ERR, DOUT}, {1'b1, 1'b0, 4'd1});
        step(PEEK, 5, 0);
        expect_eq("peek5_err", {DOUT_VALID, ERR, DOUT}, {1'b0, 1'b1, 4'd1});
        step(PEEK, 7, 0);
        expect_eq("peek7_err", {DOUT_VALID, ERR, COUNT}, {1'b0, 1'b1, 3'd5});
        step(NOP, 0, 0);
        expect_eq("nop_hold", {DOUT_VALID, ERR, DOUT}, {1'b0, 1'b0, 4'd1});

        // Full-PUSH policy
        step(PUSH, 0, 4'd6);
`ifdef STACK_ENGINE_CIRCULAR_EN
        expect_eq("push_full_ovw", {ERR, COUNT}, {1'b0, 3'd5});
        for (int k = 6; k >= 2; k--) pop_expect("pop_ovw", 4'(k));
        step(POP, 0, 0);
        expect_eq("pop6_err", {DOUT_VALID, ERR}, 2'b01);
`else
        expect_eq("push_full_rej", {ERR, COUNT}, {1'b1, 3'd5});
        for (int k = 5; k >= 1; k--) pop_expect("pop_rej", 4'(k));
`endif
        expect_eq("drained", {EMPTY, COUNT}, {1'b1, 3'd0});

        // Push then pop back to back, and a PEEK below top
        step(PUSH, 0, 4'hC);
        pop_expect("b2b", 4'hC);
        step(PUSH, 0, 4'hA);
        step(PUSH, 0, 4'hB);
        step(PEEK, 1, 0);
        expect_eq("peek1", {DOUT_VALID, DOUT}, {1'b1, 4'hA});
        step(PEEK, 2, 0);
        expect_eq("peek_oor", {ERR, DOUT}, {1'b1, 4'hA});

        // Reset mid-sequence wins over a PUSH on the same edge
        RESET = 1'b1;
        step(PUSH, 0, 4'hF);
        RESET = 1'b0;
        expect_eq("midrst", {EMPTY, COUNT, DOUT}, {1'b1, 3'd0, 4'd0});
        step(POP, 0, 0);
        expect_eq("midrst_pop", {DOUT_VALID, ERR}, 2'b01);

        // WIDTH=8, DEPTH=4 instance
        c2 = PUSH; d2 = 8'h3C;
        @(posedge CLK); #1;
        c2 = POP;
        @(posedge CLK); #1;
        expect_eq("w8_pop", {v2, q2}, {1'b1, 8'h3C});
        c2 = PUSH; d2 = 8'h11;
        @(posedge CLK); #1;
        expect_eq("w8_count1", n2, 1);
        r2 = 1'b1; c2 = PUSH; d2 = 8'hA5;
        @(posedge CLK); #1;
        expect_eq("w8_rst_push", {n2, q2, e2, f2}, {3'd0, 8'h00, 1'b1, 1'b0});
        r2 = 1'b0; c2 = POP;
        @(posedge CLK); #1;
        c2 = NOP;
        expect_eq("w8_pop_err", {x2, v2}, 2'b10);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end
endmodule
